// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file write controller.
// Holds the datapath widths, the FSM state enum and the writeback payload struct.
package rf_ctrl_pkg;

    localparam int REG_W            = 19;
    localparam int SEL_W            = 4;
    localparam int MEM_DATA_REG     = 1;
    localparam int NUM_REGS_DEFAULT = 14;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [REG_W-1:0] data;
    } wb_t;

endpackage

// File: rtl/rf_wb_skid.sv
// One-entry skid buffer that parks an ALU writeback while the C bus is busy with a load.
// Push has priority; push and pop never coincide because the controller drops ready while full.
module rf_wb_skid
    import rf_ctrl_pkg::*;
(
    input  logic clk,
    input  logic RST_N,
    input  logic push,
    input  wb_t  push_data,
    input  logic pop,
    output wb_t  pop_data,
    output logic full
);

    wb_t entry;

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            full  <= 1'b0;
            entry <= '0;
        end else if (push) begin
            full  <= 1'b1;
            entry <= push_data;
        end else if (pop) begin
            full  <= 1'b0;
        end
    end

    assign pop_data = entry;

endmodule

// File: rtl/rf_ctrl.sv
// Register-file C-bus arbiter: zero-sweeps the file after reset or on request, then
// merges zero-latency ALU writebacks with data-memory loads into R1.
module rf_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEFAULT
) (
    input  logic              clk,
    input  logic              RST_N,
    input  logic              clr_req,
    output logic              busy,
    input  logic              alu_wr_vld,
    input  logic [SEL_W-1:0]  alu_wr_sel,
    input  logic [REG_W-1:0]  alu_wr_data,
    output logic              alu_wr_rdy,
    input  logic              ld_req,
    output logic              ld_ack,
    output logic              dm_rd_en,
    input  logic              dm_rd_vld,
    output logic              C_EN,
    output logic [SEL_W-1:0]  C_SEL,
    output logic [REG_W-1:0]  c_out,
    output logic              MEM_READ,
    output logic              err
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_REGS - 1);

    state_t           state;
    state_t           state_n;
    logic [SEL_W-1:0] clr_cnt;
    logic             ld_pend;
    logic             clr_pend;
    logic             err_q;

    logic             buf_push;
    logic             buf_pop;
    logic             buf_full;
    wb_t              buf_in;
    wb_t              buf_out;

    assign MEM_READ = dm_rd_vld & ld_pend;
    assign dm_rd_en = ld_ack;
    assign err      = err_q;
    assign buf_in   = '{sel: alu_wr_sel, data: alu_wr_data};

    // A pending buffered write always wins the bus over a new ALU write, which is
    // why ready is held low while the buffer is full.
    always_comb begin
        state_n    = state;
        busy       = 1'b1;
        alu_wr_rdy = 1'b0;
        ld_ack     = 1'b0;
        C_EN       = 1'b0;
        C_SEL      = '0;
        c_out      = '0;
        buf_push   = 1'b0;
        buf_pop    = 1'b0;

        case (state)
            INIT: begin
                state_n = CLEAR;
            end
            CLEAR: begin
                C_EN  = 1'b1;
                C_SEL = clr_cnt;
                if (clr_cnt == LAST_SEL) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                busy       = clr_pend;
                alu_wr_rdy = !buf_full && !clr_pend;
                ld_ack     = ld_req && !ld_pend && !clr_pend;
                if (clr_req) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (!ld_pend && !buf_full) begin
                    state_n = CLEAR;
                end
            end
            default: begin
                state_n = INIT;
            end
        endcase

        if (state == RUN || state == DRAIN) begin
            if (buf_full && !MEM_READ) begin
                C_EN    = 1'b1;
                C_SEL   = buf_out.sel;
                c_out   = buf_out.data;
                buf_pop = 1'b1;
            end else if (alu_wr_vld && alu_wr_rdy) begin
                if (MEM_READ) begin
                    buf_push = 1'b1;
                end else begin
                    C_EN  = 1'b1;
                    C_SEL = alu_wr_sel;
                    c_out = alu_wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state    <= INIT;
            clr_cnt  <= '0;
            ld_pend  <= 1'b0;
            clr_pend <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= state_n;

            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end else begin
                clr_cnt <= '0;
            end

            if (ld_ack) begin
                ld_pend <= 1'b1;
            end else if (dm_rd_vld) begin
                ld_pend <= 1'b0;
            end

            // clr_pend spans DRAIN and the sweep so RUN cannot accept work mid-clear.
            if (state == RUN && clr_req) begin
                clr_pend <= 1'b1;
            end else if (state == CLEAR && clr_cnt == LAST_SEL) begin
                clr_pend <= 1'b0;
            end

            if (dm_rd_vld && !ld_pend) begin
                err_q <= 1'b1;
            end
        end
    end

    rf_wb_skid u_skid (
        .clk       (clk),
        .RST_N     (RST_N),
        .push      (buf_push),
        .push_data (buf_in),
        .pop       (buf_pop),
        .pop_data  (buf_out),
        .full      (buf_full)
    );

endmodule

// File: tb/tb_rf_ctrl.sv
// Directed bench for rf_ctrl: reset sweep, direct and skid-buffered writes, loads,
// clear-with-drain, the stray-read error flag and reset mid-sweep.
module tb_rf_ctrl;

    logic        clk = 1'b0;
    logic        RST_N = 1'b0;
    logic        clr_req = 1'b0;
    logic        busy;
    logic        alu_wr_vld = 1'b0;
    logic [3:0]  alu_wr_sel = '0;
    logic [18:0] alu_wr_data = '0;
    logic        alu_wr_rdy;
    logic        ld_req = 1'b0;
    logic        ld_ack;
    logic        dm_rd_en;
    logic        dm_rd_vld = 1'b0;
    logic        C_EN;
    logic [3:0]  C_SEL;
    logic [18:0] c_out;
    logic        MEM_READ;
    logic        err;

    int passCount  = 0;
    int failCount  = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    rf_ctrl #(.NUM_REGS(14)) dut (
        .clk         (clk),
        .RST_N       (RST_N),
        .clr_req     (clr_req),
        .busy        (busy),
        .alu_wr_vld  (alu_wr_vld),
        .alu_wr_sel  (alu_wr_sel),
        .alu_wr_data (alu_wr_data),
        .alu_wr_rdy  (alu_wr_rdy),
        .ld_req      (ld_req),
        .ld_ack      (ld_ack),
        .dm_rd_en    (dm_rd_en),
        .dm_rd_vld   (dm_rd_vld),
        .C_EN        (C_EN),
        .C_SEL       (C_SEL),
        .c_out       (c_out),
        .MEM_READ    (MEM_READ),
        .err         (err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int vld, input int sel, input int data,
                                 input int ld, input int rv, input int clr);
        alu_wr_vld  = 1'(vld);
        alu_wr_sel  = 4'(sel);
        alu_wr_data = 19'(data);
        ld_req      = 1'(ld);
        dm_rd_vld   = 1'(rv);
        clr_req     = 1'(clr);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sampleCycle();
        @(negedge clk);
    endtask

    initial begin
        $display("[TB] start");

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        sampleCycle();
        checkOutput("rst_c_en",   32'(C_EN), 32'd0);
        checkOutput("rst_c_sel",  32'(C_SEL), 32'd0);
        checkOutput("rst_c_out",  32'(c_out), 32'd0);
        checkOutput("rst_memrd",  32'(MEM_READ), 32'd0);
        checkOutput("rst_dm_en",  32'(dm_rd_en), 32'd0);
        checkOutput("rst_ld_ack", 32'(ld_ack), 32'd0);
        checkOutput("rst_rdy",    32'(alu_wr_rdy), 32'd0);
        checkOutput("rst_busy",   32'(busy), 32'd1);
        checkOutput("rst_err",    32'(err), 32'd0);

        // INIT cycle right after release
        nextCycle();
        RST_N = 1'b1;
        sampleCycle();
        checkOutput("init_c_en", 32'(C_EN), 32'd0);
        checkOutput("init_busy", 32'(busy), 32'd1);

        // Power-on sweep with a load request that must be refused
        for (int i = 0; i < 14; i++) begin
            nextCycle();
            applyStimulus(0, 0, 0, 1, 0, 0);
            sampleCycle();
            checkOutput($sformatf("clr_c_en_%0d", i), 32'(C_EN), 32'd1);
            checkOutput($sformatf("clr_c_sel_%0d", i), 32'(C_SEL), 32'(i));
            checkOutput($sformatf("clr_c_out_%0d", i), 32'(c_out), 32'd0);
            checkOutput($sformatf("clr_busy_%0d", i), 32'(busy), 32'd1);
            checkOutput($sformatf("clr_ld_ack_%0d", i), 32'(ld_ack), 32'd0);
            checkOutput($sformatf("clr_rdy_%0d", i), 32'(alu_wr_rdy), 32'd0);
        end

        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        sampleCycle();
        checkOutput("run_busy", 32'(busy), 32'd0);
        checkOutput("run_rdy",  32'(alu_wr_rdy), 32'd1);
        checkOutput("run_c_en", 32'(C_EN), 32'd0);

        // Zero-latency ALU write
        nextCycle();
        applyStimulus(1, 5, 'h1ABCD, 0, 0, 0);
        sampleCycle();
        checkOutput("alu_c_en",  32'(C_EN), 32'd1);
        checkOutput("alu_c_sel", 32'(C_SEL), 32'd5);
        checkOutput("alu_c_out", 32'(c_out), 32'h1ABCD);

        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        sampleCycle();
        checkOutput("idle_c_en",  32'(C_EN), 32'd0);
        checkOutput("idle_c_out", 32'(c_out), 32'd0);

        // Load handshake, second request refused
        nextCycle();
        applyStimulus(0, 0, 0, 1, 0, 0);
        sampleCycle();
        checkOutput("ld1_ack",   32'(ld_ack), 32'd1);
        checkOutput("ld1_dm_en", 32'(dm_rd_en), 32'd1);

        nextCycle();
        applyStimulus(0, 0, 0, 1, 0, 0);
        sampleCycle();
        checkOutput("ld2_ack",   32'(ld_ack), 32'd0);
        checkOutput("ld2_dm_en", 32'(dm_rd_en), 32'd0);
        checkOutput("ld2_memrd", 32'(MEM_READ), 32'd0);

        // Collision with R1 write goes to the skid buffer
        nextCycle();
        applyStimulus(1, 1, 7, 0, 1, 0);
        sampleCycle();
        checkOutput("col_memrd", 32'(MEM_READ), 32'd1);
        checkOutput("col_c_en",  32'(C_EN), 32'd0);
        checkOutput("col_c_out", 32'(c_out), 32'd0);
        checkOutput("col_rdy",   32'(alu_wr_rdy), 32'd1);

        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        sampleCycle();
        checkOutput("skid_c_en",  32'(C_EN), 32'd1);
        checkOutput("skid_c_sel", 32'(C_SEL), 32'd1);
        checkOutput("skid_c_out", 32'(c_out), 32'd7);
        checkOutput("skid_rdy",   32'(alu_wr_rdy), 32'd0);
        checkOutput("skid_err",   32'(err), 32'd0);

        nextCycle();
        sampleCycle();
        checkOutput("post_rdy",  32'(alu_wr_rdy), 32'd1);
        checkOutput("post_c_en", 32'(C_EN), 32'd0);

        // Clear with a load outstanding
        nextCycle();
        applyStimulus(0, 0, 0, 1, 0, 0);
        sampleCycle();
        checkOutput("dr_ld_ack", 32'(ld_ack), 32'd1);

        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 1);
        sampleCycle();
        checkOutput("dr_req_busy", 32'(busy), 32'd0);

        nextCycle();
        applyStimulus(1, 2, 5, 1, 0, 0);
        sampleCycle();
        checkOutput("dr_busy",   32'(busy), 32'd1);
        checkOutput("dr_ld_ack0", 32'(ld_ack), 32'd0);
        checkOutput("dr_rdy",    32'(alu_wr_rdy), 32'd0);
        checkOutput("dr_c_en",   32'(C_EN), 32'd0);

        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 0);
        sampleCycle();
        checkOutput("dr_memrd", 32'(MEM_READ), 32'd1);
        checkOutput("dr_err",   32'(err), 32'd0);

        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        sampleCycle();
        checkOutput("dr_end_busy", 32'(busy), 32'd1);
        checkOutput("dr_end_c_en", 32'(C_EN), 32'd0);

        // Second sweep; clr_req during it is ignored
        for (int i = 0; i < 14; i++) begin
            nextCycle();
            applyStimulus(0, 0, 0, 0, 0, 1);
            sampleCycle();
            checkOutput($sformatf("sw2_c_en_%0d", i), 32'(C_EN), 32'd1);
            checkOutput($sformatf("sw2_c_sel_%0d", i), 32'(C_SEL), 32'(i));
        end

        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        sampleCycle();
        checkOutput("run2_busy", 32'(busy), 32'd0);
        checkOutput("run2_rdy",  32'(alu_wr_rdy), 32'd1);

        // Stray read data sets the sticky error
        nextCycle();
        applyStimulus(0, 0, 0, 0, 1, 0);
        sampleCycle();
        checkOutput("stray_memrd", 32'(MEM_READ), 32'd0);
        checkOutput("stray_err0",  32'(err), 32'd0);

        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        sampleCycle();
        checkOutput("stray_err1", 32'(err), 32'd1);

        // Clear while a write sits in the skid buffer
        nextCycle();
        applyStimulus(0, 0, 0, 1, 0, 0);
        sampleCycle();
        checkOutput("db_ld_ack", 32'(ld_ack), 32'd1);

        nextCycle();
        applyStimulus(1, 1, 3, 0, 1, 1);
        sampleCycle();
        checkOutput("db_memrd", 32'(MEM_READ), 32'd1);
        checkOutput("db_c_en0", 32'(C_EN), 32'd0);

        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        sampleCycle();
        checkOutput("db_c_en1",  32'(C_EN), 32'd1);
        checkOutput("db_c_sel",  32'(C_SEL), 32'd1);
        checkOutput("db_c_out",  32'(c_out), 32'd3);
        checkOutput("db_busy",   32'(busy), 32'd1);

        nextCycle();
        sampleCycle();
        checkOutput("db_empty_c_en", 32'(C_EN), 32'd0);

        nextCycle();
        sampleCycle();
        checkOutput("db_clr_c_en",  32'(C_EN), 32'd1);
        checkOutput("db_clr_c_sel", 32'(C_SEL), 32'd0);
        checkOutput("db_err_held",  32'(err), 32'd1);

        // Reset mid-sweep restarts from INIT
        nextCycle();
        RST_N = 1'b0;
        sampleCycle();
        checkOutput("mid_rst_c_en", 32'(C_EN), 32'd0);
        checkOutput("mid_rst_err",  32'(err), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd1);

        nextCycle();
        RST_N = 1'b1;
        sampleCycle();
        checkOutput("re_init_c_en", 32'(C_EN), 32'd0);

        nextCycle();
        sampleCycle();
        checkOutput("re_clr0_c_en",  32'(C_EN), 32'd1);
        checkOutput("re_clr0_c_sel", 32'(C_SEL), 32'd0);

        nextCycle();
        sampleCycle();
        checkOutput("re_clr1_c_sel", 32'(C_SEL), 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/rf_ctrl.md
RF_CTRL -- requirements
Module: rf_ctrl

Interface
REQ-001 The block SHALL have one parameter: NUM_REGS, default 14, number of register-file entries swept on clear.
REQ-002 The ports SHALL be, clock and reset first:
- clk  in  1  single clock; all state changes on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- clr_req  in  1  single-cycle pulse requesting a zero-sweep of all registers.
- busy  out  1  high while a clear is pending or in progress.
- alu_wr_vld  in  1  ALU writeback request.
- alu_wr_sel  in  4  writeback destination register.
- alu_wr_data  in  19  writeback data.
- alu_wr_rdy  out  1  writeback accepted when vld&rdy.
- ld_req  in  1  request a data-memory load into R1.
- ld_ack  out  1  load request accepted this cycle.
- dm_rd_en  out  1  data-memory read strobe.
- dm_rd_vld  in  1  data-memory read data valid.
- C_EN  out  1  register-file C-bus write enable.
- C_SEL  out  4  register-file C-bus destination.
- c_out  out  19  register-file C-bus data.
- MEM_READ  out  1  register-file load-into-R1 strobe.
- err  out  1  sticky: dm_rd_vld received with no load outstanding.

Function
REQ-003 The FSM SHALL have states INIT, CLEAR, RUN and DRAIN.
REQ-004 INIT SHALL last exactly one cycle after reset release, then go to CLEAR.
REQ-005 CLEAR SHALL take exactly NUM_REGS cycles, driving C_EN=1, c_out=0 and C_SEL=0,1,...,NUM_REGS-1 in order, then go to RUN.
REQ-006 In CLEAR the block SHALL hold alu_wr_rdy=0, ld_ack=0, dm_rd_en=0 and busy=1; MEM_READ SHALL stay 0.
REQ-007 In RUN, ld_ack SHALL equal ld_req AND no load outstanding AND no clear pending (combinational); dm_rd_en SHALL equal ld_ack.
REQ-008 An accepted load SHALL set ld_pend; ld_pend SHALL clear in the cycle dm_rd_vld=1.
REQ-009 MEM_READ SHALL equal dm_rd_vld AND ld_pend (combinational); memory holds mem_data valid in that cycle.
REQ-010 alu_wr_rdy SHALL be 1 only in RUN with the skid buffer empty and no clear pending.
REQ-011 An accepted ALU write in a cycle with MEM_READ=0 SHALL drive C_EN=1, C_SEL=alu_wr_sel and c_out=alu_wr_data in that same cycle (zero latency).
REQ-012 An accepted ALU write in a cycle with MEM_READ=1 SHALL be captured in the one-entry skid buffer with C_EN=0.
REQ-013 A full buffer SHALL drain (C_EN=1 with the buffered sel/data) in the first subsequent cycle with MEM_READ=0; it SHALL be empty the following cycle.
REQ-014 An ALU write to R1 colliding with a load SHALL land after the load, so R1 ends with the ALU value.
REQ-015 clr_req in RUN SHALL set clr_pend and move the FSM to DRAIN; busy SHALL rise the next cycle.
REQ-016 DRAIN SHALL accept no new ALU writes or loads, still complete the outstanding load and drain the buffer, and go to CLEAR once ld_pend=0 and the buffer is empty.
REQ-017 clr_req received in INIT, CLEAR or DRAIN SHALL be ignored.
REQ-018 dm_rd_vld with ld_pend=0 SHALL be ignored (MEM_READ=0) and SHALL set err, which only reset clears.
REQ-019 In RUN and DRAIN, C_EN SHALL be 0 when neither a direct nor a buffered write occurs; c_out SHALL be 0 whenever C_EN=0.

Reset
REQ-020 While RST_N=0: state=INIT, ld_pend=0, buffer empty, clr_pend=0, err=0.
REQ-021 While RST_N=0 the outputs SHALL be: C_EN=0, C_SEL=0, c_out=0, MEM_READ=0, dm_rd_en=0, ld_ack=0, alu_wr_rdy=0, busy=1, err=0.
REQ-022 Reset asserted mid-CLEAR or mid-load SHALL abort the operation; after release the block restarts from INIT with a full sweep.

Structure
REQ-023 The shared package rf_ctrl_pkg SHALL hold: REG_W=19, SEL_W=4, MEM_DATA_REG=1, NUM_REGS_DEFAULT=14, and the FSM state enum.
REQ-024 The skid buffer SHALL be the sub-module rf_wb_skid: 1-entry, holding a {sel,data} payload, with push, pop, full.

Verification
REQ-025 Reset release -> 1 INIT cycle, then 14 cycles of C_EN=1 with C_SEL 0..13 and c_out=0, then busy=0 and alu_wr_rdy=1.
REQ-026 RUN, alu_wr_vld with sel=5, data=0x1ABCD -> same cycle C_EN=1, C_SEL=5, c_out=0x1ABCD.
REQ-027 ld_req -> ld_ack=dm_rd_en=1 for 1 cycle; a second ld_req before dm_rd_vld gets ld_ack=0; dm_rd_vld -> MEM_READ=1 and err stays 0.
REQ-028 ALU write sel=1, data=0x7 in the MEM_READ cycle -> C_EN=0 that cycle, C_EN=1 with sel=1, data=0x7 the next cycle, alu_wr_rdy=0 for one cycle.
REQ-029 clr_req with a load outstanding -> DRAIN, no ack/rdy; after dm_rd_vld, 14-cycle sweep; then RUN.
REQ-030 dm_rd_vld with no load outstanding -> MEM_READ=0, err=1 held until RST_N=0.
